// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver with bit-centre sampling, a byte FIFO behind a registered
// valid/ready head, and framing-error, overflow and accepted-byte status.
module uart_rx_monitor #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_rx,
   output logic [7:0]  o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_frame_err,
   output logic        o_overflow,
   output logic [31:0] o_byte_cnt,
   output logic [2:0]  o_dbg_state
);

   localparam int DIV  = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
   localparam int HALF = DIV / 2;
   localparam int TW   = $clog2(DIV);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CW   = AW + 1;

   if (DIV < 4) begin : g_div_check
      $error("uart_rx_monitor: clock/baud ratio must be at least 4");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("uart_rx_monitor: FIFO_DEPTH must be a power of two >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   // Synchroniser and edge history reset high so a low line after reset
   // reads as a fresh falling edge.
   logic rx_meta;
   logic rx_s;
   logic rx_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          tick;
   logic          push;

   assign tick        = (timer == '0);
   assign push        = (state == S_STOP) && tick && rx_s;
   assign o_dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         o_frame_err <= 1'b0;
      end else begin
         o_frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!rx_s && rx_prev) begin
                  state <= S_START;
                  timer <= TW'(HALF - 1);
               end
            end
            S_START: begin
               if (tick) begin
                  timer   <= TW'(DIV - 1);
                  bit_idx <= '0;
                  state   <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_DATA: begin
               if (tick) begin
                  timer   <= TW'(DIV - 1);
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (rx_s) begin
                     state <= S_IDLE;
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= S_BREAK;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            S_BREAK: begin
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Handshake: a byte transfers on every rising edge where o_valid && i_ready;
   // o_data is held while o_valid && !i_ready. The head register counts as one
   // of the FIFO_DEPTH entries.
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_n;
   logic [CW-1:0] count;
   logic [CW-1:0] remain;
   logic          pop;
   logic          full;
   logic          push_ok;

   assign pop      = o_valid && i_ready;
   assign full     = (count == CW'(FIFO_DEPTH));
   assign push_ok  = push && (!full || pop);
   assign rd_ptr_n = rd_ptr + AW'(pop);
   assign remain   = count - CW'(pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_overflow <= 1'b0;
         o_byte_cnt <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr     <= wr_ptr + 1'b1;
            o_byte_cnt <= o_byte_cnt + 32'd1;
         end
         if (push && !push_ok) o_overflow <= 1'b1;
         rd_ptr  <= rd_ptr_n;
         count   <= count + CW'(push_ok) - CW'(pop);
         // Head only reloads from entries already stored before this edge.
         o_valid <= (remain != '0);
         if (remain != '0) o_data <= mem[rd_ptr_n];
      end
   end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Synthesizable UART receiver that consumes the core's serial `o_uart_tx` line and turns it into a byte stream, downstream of `swervolf_core`. It uses 8N1 framing with bit-centre sampling, and an internal byte FIFO with a valid/ready output. It also provides framing-error and overflow status plus an accepted-byte counter. Used by simulation benches (Verilator-friendly) for console capture and self-checking, and reusable on FPGA targets.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line rate.
FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous active-high reset.
i_rx  input  1  serial line, idle high, asynchronous to clk.
o_data  output  8  FIFO head byte.
o_valid  output  1  o_data holds a valid byte.
i_ready  input  1  consumer accepts o_data when o_valid && i_ready.
o_frame_err  output  1  one-cycle pulse on stop-bit error.
o_overflow  output  1  sticky: a byte was dropped because the FIFO was full.
o_byte_cnt  output  32  count of bytes written into the FIFO; wraps at 2^32.

Behaviour:
- Reset values:
  - o_valid=0, o_data=0, o_frame_err=0, o_overflow=0, o_byte_cnt=0.
  - FIFO empty, FSM in IDLE.
  - Synchroniser flops =1.
- Input conditioning: i_rx passes through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
- Timing constants:
  - DIV = (CLK_FREQ_HZ + BAUD/2) / BAUD.
  - HALF = DIV/2 (integer). Elaboration error if DIV < 4.
- Start detection: start edge = cycle T where rx_s=0 and its previous value =1, FSM in IDLE.
- Sample points: T+HALF+k·DIV, k=0..9.
  - k=0: start bit. k=1..8: data, LSB first. k=9: stop bit.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE→START on start edge; bit timer loaded.
  - START: at sample, rx_s=1 → false start, back to IDLE with no side effects; rx_s=0 → DATA.
  - DATA: shift in 8 bits, then → STOP.
  - STOP, rx_s=1: push byte (cycle after sample), → IDLE. A new start edge may be detected from the cycle after the stop sample.
  - STOP, rx_s=0: o_frame_err pulses for 1 cycle the cycle after sample; byte discarded; → BREAK.
  - BREAK → IDLE on the first cycle rx_s=1. A low line never produces further frames or errors.
- FIFO:
  - Push writes at the cycle after the stop sample. o_byte_cnt increments in the same cycle as a successful push.
  - Output is registered with no combinational bypass. o_valid rises the cycle after a push into an empty FIFO, i.e. at T+HALF+9·DIV+2.
  - Pop on o_valid && i_ready; the next entry (if any) is presented the following cycle.
  - Full with push and no pop: byte dropped, o_overflow set (sticky until rst), o_byte_cnt unchanged.
  - Full with push and pop in the same cycle: both occur, no overflow.
  - Ordering is strictly FIFO.
  - o_data is held stable while o_valid && !i_ready.
- Reset mid-frame: FSM returns to IDLE and the FIFO empties. The partially received frame is lost. The line must be seen high→low again (synchronisers reset to 1) before reception resumes.

Test Plan:
1. CLK_FREQ_HZ=16, BAUD=1 (DIV=16); drive 0x55 8N1, i_ready=1 → o_valid high exactly one cycle at T+8+144+2 with o_data=0x55; o_byte_cnt=1; o_frame_err never asserted.
2. i_rx low for 4 cycles, then high → no push, no o_frame_err, o_byte_cnt=0; a following 0xC3 frame is received correctly.
3. 0xA5 frame with stop bit 0, line held low 40 cycles, then high, then 0x3C frame → one o_frame_err pulse, no byte for 0xA5; 0x3C delivered; o_byte_cnt=1.
4. i_ready=0; send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 → o_overflow=1 after the 17th, o_byte_cnt=16; raising i_ready drains 0x00..0x0F in order, one per cycle; o_valid drops after 0x0F.
5. Assert rst for 1 cycle during data bit 4 of a frame → all outputs at reset values next cycle; a subsequent 0x81 frame is received correctly; o_byte_cnt=1.
6. Back-to-back 0xFF then 0x00, with the second start bit immediately after the first stop bit → both bytes delivered in order, no frame errors.
